// File: rtl/gps_srq_sched_pkg.sv
// Shared definitions for the GPS service-request scheduler: FSM encoding,
// host starvation limit and channel-count defaults shared with the GPS top.
package gps_srq_sched_pkg;

  localparam int GPS_CHANS_DEF = 12;
  localparam int CHAN_W_DEF    = 4;
  localparam int STARVE_LIM    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/gps_rr_pick.sv
// Rotating-priority encoder: returns the first set request at or after i_start,
// wrapping modulo N. Purely combinational.
module gps_rr_pick #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [W:0]   w_sum [N];
  logic [W-1:0] w_pos [N];

  for (genvar k = 0; k < N; k++) begin : g_pos
    assign w_sum[k] = {1'b0, i_start} + (W+1)'(k);
    assign w_pos[k] = (w_sum[k] >= (W+1)'(N)) ? W'(w_sum[k] - (W+1)'(N))
                                               : w_sum[k][W-1:0];
  end

  // Walk from the farthest position back so the nearest hit overwrites last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[w_pos[k]]) begin
        o_found = 1'b1;
        o_idx   = w_pos[k];
      end
    end
  end

endmodule

// File: rtl/gps_srq_sched.sv
// Round-robin service-request scheduler for the demod bank plus host, with
// lost-epoch detection. Optional ack watchdog under GPS_SCHED_WDOG_EN.
module gps_srq_sched
  import gps_srq_sched_pkg::*;
#(
  parameter int GPS_CHANS = GPS_CHANS_DEF,
  parameter int CHAN_W    = CHAN_W_DEF,
  parameter int OVR_W     = 8,
  parameter int TMO_CYC   = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [GPS_CHANS-1:0] i_chan_srq,
  input  logic                 i_host_srq,
  input  logic                 i_mask_wr,
  input  logic [GPS_CHANS-1:0] i_mask_in,
  input  logic                 i_gnt_ack,
  input  logic                 i_ovr_clr,
  output logic                 o_gnt_valid,
  output logic                 o_gnt_host,
  output logic [CHAN_W-1:0]    o_gnt_chan,
  output logic [GPS_CHANS-1:0] o_pend,
  output logic [GPS_CHANS-1:0] o_ovr_flags,
  output logic [OVR_W-1:0]     o_ovr_cnt,
  output logic                 o_tmo
);

  if ((1 << CHAN_W) < GPS_CHANS || TMO_CYC < 2 || OVR_W < 5) begin : g_param_err
    $error("gps_srq_sched: inconsistent parameters");
  end

  sched_state_t         r_state;
  logic [GPS_CHANS-1:0] r_mask, r_pend, r_ovr_flags;
  logic [CHAN_W-1:0]    r_rr_ptr, r_gnt_chan;
  logic                 r_gnt_valid, r_gnt_host;
  logic [OVR_W-1:0]     r_ovr_cnt;
  logic [2:0]           r_starve;

  logic                 w_found, w_ack, w_host_pick;
  logic [CHAN_W-1:0]    w_pick;
  logic [GPS_CHANS-1:0] w_ack_vec, w_set, w_ovr, w_pend_nxt;
  logic [4:0]           w_ovr_n;
  logic [OVR_W:0]       w_ovr_sum;
  logic [OVR_W-1:0]     w_ovr_sat;

  gps_rr_pick #(.N(GPS_CHANS), .W(CHAN_W)) u_pick (
    .i_req   (r_pend),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_ack = i_gnt_ack && (r_state == ST_WAIT);

  always_comb begin
    w_ack_vec = '0;
    for (int i = 0; i < GPS_CHANS; i++)
      w_ack_vec[i] = w_ack && !r_gnt_host && (r_gnt_chan == CHAN_W'(i));
  end

  // A new epoch in the ack cycle re-arms pend rather than counting as lost.
  assign w_set      = i_chan_srq & r_mask;
  assign w_ovr      = w_set & r_pend & ~w_ack_vec;
  assign w_pend_nxt = ((r_pend & ~w_ack_vec) | w_set) & (i_mask_wr ? i_mask_in : '1);

  always_comb begin
    w_ovr_n = '0;
    for (int i = 0; i < GPS_CHANS; i++) w_ovr_n = w_ovr_n + 5'(w_ovr[i]);
  end

  assign w_ovr_sum   = {1'b0, r_ovr_cnt} + (OVR_W+1)'(w_ovr_n);
  assign w_ovr_sat   = w_ovr_sum[OVR_W] ? '1 : w_ovr_sum[OVR_W-1:0];
  assign w_host_pick = i_host_srq && (!w_found || (r_starve >= 3'(STARVE_LIM)));

`ifdef GPS_SCHED_WDOG_EN
  localparam int WD_W = $clog2(TMO_CYC);
  logic [WD_W-1:0] r_wd;
  logic            r_tmo;
  assign o_tmo = r_tmo;
`else
  assign o_tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_pend      <= '0;
      r_ovr_flags <= '0;
      r_ovr_cnt   <= '0;
      r_rr_ptr    <= '0;
      r_gnt_chan  <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_host  <= 1'b0;
      r_starve    <= '0;
`ifdef GPS_SCHED_WDOG_EN
      r_wd        <= '0;
      r_tmo       <= 1'b0;
`endif
    end else begin
      r_pend <= w_pend_nxt;
      if (i_mask_wr) r_mask <= i_mask_in;
      if (i_ovr_clr) begin
        r_ovr_flags <= '0;
        r_ovr_cnt   <= '0;
`ifdef GPS_SCHED_WDOG_EN
        r_tmo       <= 1'b0;
`endif
      end else begin
        r_ovr_flags <= r_ovr_flags | w_ovr;
        if (|w_ovr) r_ovr_cnt <= w_ovr_sat;
      end
      if (!i_host_srq) r_starve <= '0;

      case (r_state)
        ST_IDLE: begin
          if ((|r_pend) || i_host_srq) r_state <= ST_GRANT;
        end
        ST_GRANT: begin
`ifdef GPS_SCHED_WDOG_EN
          r_wd <= '0;
`endif
          if (w_host_pick) begin
            r_gnt_valid <= 1'b1;
            r_gnt_host  <= 1'b1;
            r_gnt_chan  <= '0;
            r_starve    <= '0;
            r_state     <= ST_WAIT;
          end else if (w_found) begin
            r_gnt_valid <= 1'b1;
            r_gnt_host  <= 1'b0;
            r_gnt_chan  <= w_pick;
            r_rr_ptr    <= (w_pick == CHAN_W'(GPS_CHANS - 1)) ? '0 : w_pick + CHAN_W'(1);
            if (i_host_srq && (r_starve < 3'(STARVE_LIM))) r_starve <= r_starve + 3'd1;
            r_state     <= ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (i_gnt_ack) begin
            r_gnt_valid <= 1'b0;
            r_gnt_host  <= 1'b0;
            r_gnt_chan  <= '0;
            r_state     <= ST_IDLE;
          end
`ifdef GPS_SCHED_WDOG_EN
          // Timeout abandons the grant but keeps pend so the channel is re-served.
          else if (r_wd == WD_W'(TMO_CYC - 1)) begin
            r_gnt_valid <= 1'b0;
            r_gnt_host  <= 1'b0;
            r_gnt_chan  <= '0;
            r_tmo       <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_host  = r_gnt_host;
  assign o_gnt_chan  = r_gnt_chan;
  assign o_pend      = r_pend;
  assign o_ovr_flags = r_ovr_flags;
  assign o_ovr_cnt   = r_ovr_cnt;

endmodule
